// File: rtl/morse_sym_ctrl.sv
// Morse keying controller: times key presses, classifies each as dot or dash,
// assembles up to MAXSYM elements per letter and presents the finished letter
// over a valid/ready handshake once a letter gap has elapsed.
//
// Handshake: sym_valid rises on entry to HOLD and stays high, with sym_bits,
// sym_len and sym_ovf frozen, until the first rising edge where sym_ready=1;
// that edge is the accept edge, after which sym_valid is 0.
// sym_ready is ignored whenever sym_valid is 0.
module morse_sym_ctrl #(
   parameter int DOT_MAX = 4,
   parameter int GAP_CYC = 8,
   parameter int MAXSYM  = 6,
   parameter int CW      = 16,
   parameter int LW      = $clog2(MAXSYM + 1)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              key_in,
   input  logic              sym_ready,
   output logic              sym_valid,
   output logic [MAXSYM-1:0] sym_bits,
   output logic [LW-1:0]     sym_len,
   output logic              sym_ovf,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      GAP   = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [MAXSYM-1:0] bits;
   logic [LW-1:0]     len;
   logic              ovf;

   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] DOT_LIM  = CW'(DOT_MAX);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
   localparam logic [LW-1:0] LEN_MAX  = LW'(MAXSYM);

   // Status is decoded straight from the state register.
   always_comb begin
      busy      = (state != IDLE);
      dbg_state = state;
   end

   // Letter assembly FSM with registered letter outputs; the internal
   // bits/len/ovf are copied to the outputs only when the letter is presented.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= IDLE;
         cnt       <= '0;
         bits      <= '0;
         len       <= '0;
         ovf       <= 1'b0;
         sym_valid <= 1'b0;
         sym_bits  <= '0;
         sym_len   <= '0;
         sym_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (key_in) begin
                  state <= PRESS;
                  cnt   <= CW'(1);
               end
            end
            PRESS: begin
               if (key_in) begin
                  // Saturate so an over-long press stays a dash.
                  if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
               end else begin
                  if (len < LEN_MAX) begin
                     bits[len] <= (cnt > DOT_LIM);
                     len       <= len + LW'(1);
                  end else begin
                     ovf <= 1'b1;
                  end
                  state <= GAP;
                  cnt   <= CW'(1);
               end
            end
            GAP: begin
               // A press on the terminal gap cycle continues the letter.
               if (key_in) begin
                  state <= PRESS;
                  cnt   <= CW'(1);
               end else if (cnt == GAP_LAST) begin
                  state     <= HOLD;
                  sym_valid <= 1'b1;
                  sym_bits  <= bits;
                  sym_len   <= len;
                  sym_ovf   <= ovf;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            HOLD: begin
               if (sym_ready) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  bits      <= '0;
                  len       <= '0;
                  ovf       <= 1'b0;
                  sym_valid <= 1'b0;
                  sym_bits  <= '0;
                  sym_len   <= '0;
                  sym_ovf   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_morse_sym_ctrl.sv
// Directed bench for morse_sym_ctrl with DOT_MAX=4, GAP_CYC=8, MAXSYM=6.
module tb_morse_sym_ctrl;

   logic       clk;
   logic       nrst;
   logic       key_in;
   logic       sym_ready;
   logic       sym_valid;
   logic [5:0] sym_bits;
   logic [2:0] sym_len;
   logic       sym_ovf;
   logic       busy;
   logic [1:0] dbg_state;

   int checks   = 0;
   int failures = 0;

   morse_sym_ctrl #(
      .DOT_MAX(4),
      .GAP_CYC(8),
      .MAXSYM (6),
      .CW     (16)
   ) dut (
      .clk      (clk),
      .nrst     (nrst),
      .key_in   (key_in),
      .sym_ready(sym_ready),
      .sym_valid(sym_valid),
      .sym_bits (sym_bits),
      .sym_len  (sym_len),
      .sym_ovf  (sym_ovf),
      .busy     (busy),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks: every step ends 1ns after a rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input int n);
      key_in = 1'b1;
      repeat (n) cyc();
   endtask

   task automatic low(input int n);
      key_in = 1'b0;
      repeat (n) cyc();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_letter(input string tag, input logic [5:0] eb, input logic [2:0] el,
                             input logic eo);
      chk({tag, "_valid"}, 32'(sym_valid), 32'd1);
      chk({tag, "_bits"},  32'(sym_bits),  32'(eb));
      chk({tag, "_len"},   32'(sym_len),   32'(el));
      chk({tag, "_ovf"},   32'(sym_ovf),   32'(eo));
      chk({tag, "_busy"},  32'(busy),      32'd1);
   endtask

   task automatic accept(input string tag);
      sym_ready = 1'b1;
      cyc();
      sym_ready = 1'b0;
      chk({tag, "_acc_valid"}, 32'(sym_valid), 32'd0);
      chk({tag, "_acc_len"},   32'(sym_len),   32'd0);
      chk({tag, "_acc_bits"},  32'(sym_bits),  32'd0);
      chk({tag, "_acc_busy"},  32'(busy),      32'd0);
   endtask

   initial begin
      nrst      = 1'b0;
      key_in    = 1'b0;
      sym_ready = 1'b0;
      repeat (3) cyc();
      chk("rst_valid", 32'(sym_valid), 32'd0);
      chk("rst_bits",  32'(sym_bits),  32'd0);
      chk("rst_len",   32'(sym_len),   32'd0);
      chk("rst_ovf",   32'(sym_ovf),   32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      nrst = 1'b1;
      low(2);
      chk("idle_busy", 32'(busy), 32'd0);

      // single dot, letter latency: valid only after the 8th low sample
      press(1);
      chk("e_busy_press", 32'(busy), 32'd1);
      press(2);
      low(7);
      chk("e_valid_7low", 32'(sym_valid), 32'd0);
      chk("e_busy_gap",   32'(busy),      32'd1);
      low(1);
      chk_letter("e", 6'b000000, 3'd1, 1'b0);
      accept("e");

      // letter A: dot, dash
      press(3); low(2); press(10); low(8);
      chk_letter("a", 6'b000010, 3'd2, 1'b0);
      accept("a");

      // press of 4 is a dot, press of 5 is a dash
      press(4); low(2); press(5); low(8);
      chk_letter("cls", 6'b000010, 3'd2, 1'b0);
      accept("cls");

      // six low samples then press: same letter
      press(1); low(6); press(1); low(8);
      chk_letter("gap6", 6'b000000, 3'd2, 1'b0);
      accept("gap6");

      // press on the 8th sample after release continues the letter
      press(1); low(7);
      chk("term_valid_pre", 32'(sym_valid), 32'd0);
      press(1);
      chk("term_valid", 32'(sym_valid), 32'd0);
      chk("term_busy",  32'(busy),      32'd1);
      press(5); low(8);
      chk_letter("term", 6'b000010, 3'd2, 1'b0);
      accept("term");

      // backpressure: outputs frozen while key toggles
      press(5); low(8);
      chk_letter("bp0", 6'b000001, 3'd1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         key_in = 1'($urandom_range(0, 1)) ^ 1'(i);
         cyc();
         chk("bp_valid", 32'(sym_valid), 32'd1);
         chk("bp_bits",  32'(sym_bits),  32'd1);
         chk("bp_len",   32'(sym_len),   32'd1);
         chk("bp_busy",  32'(busy),      32'd1);
      end
      key_in = 1'b0;
      accept("bp");

      // overflow: seven dots, extra element dropped
      for (int i = 0; i < 7; i++) begin
         press(1);
         if (i < 6) low(2);
      end
      low(8);
      chk_letter("ovf", 6'b000000, 3'd6, 1'b1);
      accept("ovf");
      press(1); low(8);
      chk_letter("ovf_next", 6'b000000, 3'd1, 1'b0);
      accept("ovf_next");

      // key already held at the accept edge starts a press on the next edge
      press(5); low(8);
      chk_letter("held0", 6'b000001, 3'd1, 1'b0);
      key_in = 1'b1;
      accept("held");
      cyc();
      chk("held_busy", 32'(busy), 32'd1);
      press(1); low(8);
      chk_letter("held1", 6'b000000, 3'd1, 1'b0);
      accept("held1");

      // asynchronous reset mid-letter discards the partial letter
      press(1); low(2); press(1); low(2); press(2);
      chk("mr_busy_pre", 32'(busy), 32'd1);
      #3;
      nrst = 1'b0;
      #1;
      chk("mr_busy",  32'(busy),      32'd0);
      chk("mr_valid", 32'(sym_valid), 32'd0);
      chk("mr_len",   32'(sym_len),   32'd0);
      chk("mr_bits",  32'(sym_bits),  32'd0);
      key_in = 1'b0;
      repeat (2) cyc();
      nrst = 1'b1;
      low(1);
      press(5); low(8);
      chk_letter("mr", 6'b000001, 3'd1, 1'b0);
      accept("mr");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
